// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the core's
// data port and the memory arbiter. Hits answer in the cycle after capture; misses
// stall the core while a word-granular writeback and/or refill runs to memory.
module dcache_responder #(
    parameter int unsigned LOGLINES = 6,
    parameter int unsigned AWIDTH   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_din,
    output logic [31:0]       cpu_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [AWIDTH-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int unsigned NumLines = 1 << LOGLINES;
    localparam int unsigned TagW     = AWIDTH - 4 - LOGLINES;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWb      = 2'd1;
    localparam logic [1:0] StRefill  = 2'd2;
    localparam logic [1:0] StRespond = 2'd3;

    // Byte offset never matters: loads return the whole word, stores use cpu_we.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    logic [1:0]          state_q, state_d;
    logic                req_valid_q, req_valid_d;
    logic                req_re_q, req_re_d;
    logic [3:0]          req_we_q, req_we_d;
    logic [AWIDTH-1:2]   req_addr_q, req_addr_d;
    logic [31:0]         req_din_q, req_din_d;
    logic [NumLines-1:0] valid_q, valid_d;
    logic [NumLines-1:0] dirty_q, dirty_d;
    logic [1:0]          issue_q, issue_d;
    logic                issue_done_q, issue_done_d;
    logic [1:0]          rx_q, rx_d;
    logic [31:0]         dout_q, dout_d;

    // Storage without reset: contents are only trusted through valid_q.
    logic [TagW-1:0]     tag_q  [NumLines];
    logic [31:0]         data_q [NumLines][4];

    logic [LOGLINES-1:0] req_idx;
    logic [1:0]          req_word;
    logic [TagW-1:0]     req_tag;
    logic [TagW-1:0]     line_tag;
    logic [31:0]         line_word;
    logic                hit;
    logic                capture;

    logic                arr_we;
    logic [1:0]          arr_word;
    logic [31:0]         arr_wdata;
    logic                tag_we;

    assign req_idx   = req_addr_q[3+LOGLINES:4];
    assign req_word  = req_addr_q[3:2];
    assign req_tag   = req_addr_q[AWIDTH-1:4+LOGLINES];
    assign line_tag  = tag_q[req_idx];
    assign line_word = data_q[req_idx][req_word];
    assign hit       = valid_q[req_idx] && (line_tag == req_tag);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Lookup, miss handling FSM, memory request generation and array write control.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        issue_d       = issue_q;
        issue_done_d  = issue_done_q;
        rx_d          = rx_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        arr_we        = 1'b0;
        arr_word      = req_word;
        arr_wdata     = line_word;
        tag_we        = 1'b0;
        cpu_dout      = dout_q;

        case (state_q)
            StIdle: begin
                if (req_valid_q) begin
                    if (hit) begin
                        if (req_re_q) cpu_dout = line_word;
                        if (req_we_q != 4'b0) begin
                            arr_we           = 1'b1;
                            arr_wdata        = merge_bytes(line_word, req_din_q, req_we_q);
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else begin
                        stall        = 1'b1;
                        issue_d      = 2'd0;
                        issue_done_d = 1'b0;
                        rx_d         = 2'd0;
                        state_d      = (valid_q[req_idx] && dirty_q[req_idx]) ? StWb : StRefill;
                    end
                end
            end

            StWb: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {line_tag, req_idx, issue_q, 2'b00};
                mem_req_wdata = data_q[req_idx][issue_q];
                if (mem_req_ready) begin
                    // Counter wraps to 0, ready for the refill issue sequence.
                    issue_d = issue_q + 2'd1;
                    if (issue_q == 2'd3) begin
                        dirty_d[req_idx] = 1'b0;
                        state_d          = StRefill;
                    end
                end
            end

            StRefill: begin
                stall         = 1'b1;
                mem_req_valid = !issue_done_q;
                if (!issue_done_q) begin
                    mem_req_addr = {req_tag, req_idx, issue_q, 2'b00};
                end
                if (mem_req_valid && mem_req_ready) begin
                    issue_d = issue_q + 2'd1;
                    if (issue_q == 2'd3) issue_done_d = 1'b1;
                end
                // Receive side runs independently of the issue side.
                if (mem_resp_valid) begin
                    arr_we    = 1'b1;
                    arr_word  = rx_q;
                    arr_wdata = mem_resp_data;
                    rx_d      = rx_q + 2'd1;
                    if (rx_q == 2'd3) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        state_d          = StRespond;
                    end
                end
            end

            StRespond: begin
                if (req_re_q) cpu_dout = line_word;
                if (req_we_q != 4'b0) begin
                    arr_we           = 1'b1;
                    arr_wdata        = merge_bytes(line_word, req_din_q, req_we_q);
                    dirty_d[req_idx] = 1'b1;
                end
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // Request register follows the core whenever it is not stalled, frozen otherwise.
    always_comb begin
        capture    = !stall;
        req_valid_d = req_valid_q;
        req_re_d    = req_re_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_din_d   = req_din_q;
        if (capture) begin
            req_valid_d = cpu_re || (cpu_we != 4'b0);
            req_re_d    = cpu_re;
            req_we_d    = cpu_we;
            req_addr_d  = cpu_addr[AWIDTH-1:2];
            req_din_d   = cpu_din;
        end
        // Hold the last presented load word so cpu_dout stays stable between hits.
        dout_d = cpu_dout;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            req_valid_q  <= 1'b0;
            req_re_q     <= 1'b0;
            req_we_q     <= 4'b0;
            req_addr_q   <= '0;
            req_din_q    <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            issue_q      <= 2'd0;
            issue_done_q <= 1'b0;
            rx_q         <= 2'd0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_re_q     <= req_re_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_din_q    <= req_din_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            issue_q      <= issue_d;
            issue_done_q <= issue_done_d;
            rx_q         <= rx_d;
            dout_q       <= dout_d;
        end
    end

    // Tag and data arrays: single write port addressed by the registered request.
    always_ff @(posedge clk) begin
        if (arr_we) data_q[req_idx][arr_word] <= arr_wdata;
        if (tag_we) tag_q[req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder. The reference is architectural: every load must
// return the value the program last stored (or the initial memory image), and every
// writeback must carry that same value. A small in-order memory model answers reads
// one cycle after acceptance.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    dcache_responder #(.LOGLINES(6), .AWIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    // Architectural view (what loads must see) and backing memory contents.
    logic [31:0] arch_mem [logic [31:0]];
    logic [31:0] back_mem [logic [31:0]];

    logic [31:0] rd_pend [$];
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          resp_beats = 0;
    int          held_cycles = 0;
    int          hold_left = 0;
    logic        hold_arm = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_rw;

    logic [31:0] exp_wb_a [4];
    logic [31:0] exp_wb_d [4];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hC0DE0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (arch_mem.exists(w)) return arch_mem[w];
        return init_val(w);
    endfunction

    function automatic logic [31:0] back_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (back_mem.exists(w)) return back_mem[w];
        return init_val(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model plus per-cycle protocol monitor, all evaluated at the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            rd_pend.delete();
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            hold_left      = 0;
            prev_pend      = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held_valid", {31'h0, mem_req_valid}, 32'h1);
                chk("req_held_addr", mem_req_addr, prev_addr);
                chk("req_held_rw", {31'h0, mem_req_rw}, {31'h0, prev_rw});
                chk("req_held_wdata", mem_req_wdata, prev_wdata);
            end
            chk("no_req_unstalled", {31'h0, mem_req_valid & ~stall}, 32'h0);

            if (rd_pend.size() > 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = back_rd(rd_pend.pop_front());
                resp_beats++;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 32'h0;
            end

            if (hold_arm && mem_req_valid && !mem_req_rw) begin
                hold_left = 5;
                hold_arm  = 1'b0;
            end
            mem_req_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            if (mem_req_valid && !mem_req_ready) held_cycles++;

            if (mem_req_valid && mem_req_ready) begin
                chk("req_addr_aligned", {30'h0, mem_req_addr[1:0]}, 32'h0);
                if (mem_req_rw) begin
                    chk("wb_data_vs_arch", mem_req_wdata, arch_rd(mem_req_addr));
                    back_mem[mem_req_addr] = mem_req_wdata;
                    wr_addr_log.push_back(mem_req_addr);
                    wr_data_log.push_back(mem_req_wdata);
                end else begin
                    rd_pend.push_back(mem_req_addr);
                    rd_log.push_back(mem_req_addr);
                end
            end

            prev_pend  = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            prev_rw    = mem_req_rw;
            prev_wdata = mem_req_wdata;
        end
    end

    // Called at a falling edge; returns at the falling edge of the answering cycle.
    task automatic do_req(input logic [31:0] a, input logic re, input logic [3:0] we,
                          input logic [31:0] din, output int sc);
        cpu_addr = a;
        cpu_re   = re;
        cpu_we   = we;
        cpu_din  = din;
        @(posedge clk);
        sc = 0;
        @(negedge clk);
        while (stall && sc < 200) begin
            sc++;
            @(negedge clk);
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %h still stalled after %0d cycles", a, sc);
        end
        if (re) chk("load_vs_arch", cpu_dout, arch_rd(a));
        if (we != 4'b0) begin
            logic [31:0] w;
            w = arch_rd(a);
            for (int i = 0; i < 4; i++) begin
                if (we[i]) w[8*i +: 8] = din[8*i +: 8];
            end
            arch_mem[{a[31:2], 2'b00}] = w;
        end
        cpu_re = 1'b0;
        cpu_we = 4'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        held_cycles = 0;
    endtask

    task automatic chk_reads(input string name, input logic [31:0] base);
        chk({name, "_nreads"}, rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            chk({name, "_raddr"}, rd_log[i], base + 32'(4 * i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        reset         = 1'b0;
        cpu_addr      = 32'h0;
        cpu_re        = 1'b0;
        cpu_we        = 4'b0;
        cpu_din       = 32'h0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        back_mem[32'h100] = 32'h11;
        back_mem[32'h104] = 32'h22;
        back_mem[32'h108] = 32'h33;
        back_mem[32'h10C] = 32'h44;
        arch_mem[32'h100] = 32'h11;
        arch_mem[32'h104] = 32'h22;
        arch_mem[32'h108] = 32'h33;
        arch_mem[32'h10C] = 32'h44;

        repeat (3) @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_req_rw", {31'h0, mem_req_rw}, 32'h0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_req_wdata", mem_req_wdata, 32'h0);
        chk("rst_dout", cpu_dout, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Cold read miss, clean: lookup + 5 refill cycles.
        clear_logs();
        do_req(32'h100, 1'b1, 4'b0, 32'h0, sc);
        chk("miss100_dout", cpu_dout, 32'h11);
        chk("miss100_stall", sc, 6);
        chk_reads("miss100", 32'h100);

        // Back-to-back hit captured at the answering edge.
        clear_logs();
        do_req(32'h108, 1'b1, 4'b0, 32'h0, sc);
        chk("hit108_dout", cpu_dout, 32'h33);
        chk("hit108_stall", sc, 0);
        chk("hit108_noreq", rd_log.size() + wr_addr_log.size(), 0);

        do_req(32'h104, 1'b0, 4'b0011, 32'h0000BEEF, sc);
        chk("wr104_stall", sc, 0);
        do_req(32'h104, 1'b1, 4'b0, 32'h0, sc);
        chk("rd104_dout", cpu_dout, 32'h0000BEEF);
        chk("rd104_stall", sc, 0);

        // Idle cycles with a wandering address must not stall or touch memory.
        cpu_addr = 32'h0000_0F00;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stall", {31'h0, stall}, 32'h0);
            cpu_addr = cpu_addr + 32'h40;
        end

        // Conflict miss on a dirty line: writeback then refill.
        clear_logs();
        do_req(32'h500, 1'b1, 4'b0, 32'h0, sc);
        chk("miss500_dout", cpu_dout, 32'hC0DE0500);
        chk("miss500_stall", sc, 10);
        chk("miss500_nwrites", wr_addr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            chk("miss500_wb_addr", wr_addr_log[i], exp_wb_a[i]);
            chk("miss500_wb_data", wr_data_log[i], exp_wb_d[i]);
        end
        chk_reads("miss500", 32'h500);

        // Memory back-pressure for 5 cycles at the start of a refill.
        clear_logs();
        hold_arm = 1'b1;
        do_req(32'h200, 1'b1, 4'b0, 32'h0, sc);
        chk("hold200_dout", cpu_dout, 32'hC0DE0200);
        chk("hold200_stall", sc, 11);
        chk("hold200_held", held_cycles, 5);
        chk_reads("hold200", 32'h200);

        // Write miss allocates, merges, and later writes back.
        clear_logs();
        do_req(32'h604, 1'b0, 4'b1100, 32'hABCD0000, sc);
        chk("wmiss604_stall", sc, 6);
        chk_reads("wmiss604", 32'h600);
        do_req(32'h604, 1'b1, 4'b0, 32'h0, sc);
        chk("rd604_dout", cpu_dout, 32'hABCD0604);
        chk("rd604_stall", sc, 0);
        clear_logs();
        do_req(32'h200, 1'b1, 4'b0, 32'h0, sc);
        chk("rd200_stall", sc, 10);
        chk("rd200_nwrites", wr_addr_log.size(), 4);
        if (wr_addr_log.size() > 1) chk("rd200_wb1", wr_data_log[1], 32'hABCD0604);

        // Reset in the middle of a refill after two responses.
        @(negedge clk);
        clear_logs();
        resp_beats = 0;
        cpu_addr = 32'h100;
        cpu_re   = 1'b1;
        begin
            int guard;
            guard = 0;
            while (resp_beats < 2 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            chk("rst_mid_beats", resp_beats, 2);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cpu_re = 1'b0;
        #1;
        chk("rst_mid_stall", {31'h0, stall}, 32'h0);
        chk("rst_mid_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_mid_dout", cpu_dout, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        clear_logs();
        do_req(32'h100, 1'b1, 4'b0, 32'h0, sc);
        chk("post_rst_dout", cpu_dout, 32'h11);
        chk("post_rst_stall", sc, 6);
        chk_reads("post_rst", 32'h100);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        exp_wb_a[0] = 32'h100;
        exp_wb_a[1] = 32'h104;
        exp_wb_a[2] = 32'h108;
        exp_wb_a[3] = 32'h10C;
        exp_wb_d[0] = 32'h11;
        exp_wb_d[1] = 32'h0000BEEF;
        exp_wb_d[2] = 32'h33;
        exp_wb_d[3] = 32'h44;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache. It is the responder on the core's data-memory port: dcache_addr, dcache_we, dcache_re, dcache_din, dcache_dout and stall.
- Hits return load data one cycle after the request.
- Misses assert stall and run a word-granular request/response handshake to backing memory for writeback and refill.
- Sits between the core and the memory arbiter.

Parameters:
- LOGLINES, 6, log2 of number of cache lines (64 lines × 4 words = 1 KiB).
- AWIDTH, 32, byte address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- cpu_addr  input  32  byte address of request (core dcache_addr).
- cpu_re  input  1  read request.
- cpu_we  input  4  byte-write enables; non-zero = write request.
- cpu_din  input  32  store data, already lane-aligned.
- cpu_dout  output  32  full aligned load word.
- stall  output  1  core must hold all cpu_* inputs while high.
- mem_req_valid  output  1  word request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_rw  output  1  1 = write, 0 = read.
- mem_req_addr  output  32  word-aligned byte address.
- mem_req_wdata  output  32  write data.
- mem_resp_valid  input  1  read data beat valid; responses return in request order.
- mem_resp_data  input  32  read data.

Behaviour:
- Address split:
  - [1:0] byte offset (ignored).
  - [3:2] word-in-line.
  - [3+LOGLINES:4] index.
  - [31:4+LOGLINES] tag.
- Per-line state: valid, dirty, tag, 4 data words. Only valid and dirty are reset.
- Reset values: all valid = 0, all dirty = 0, FSM = IDLE, stall = 0, mem_req_valid = 0, mem_req_rw = 0, mem_req_addr = 0, mem_req_wdata = 0, cpu_dout = 0, counters = 0.
- Request capture:
  - A request exists when cpu_re = 1 or cpu_we != 0.
  - In IDLE with stall = 0, cpu_addr/cpu_we/cpu_din are registered every cycle.
  - While stall = 1, the request register is frozen and cpu_* inputs are ignored.
- Lookup:
  - Occurs in the cycle after capture, on the registered request.
  - Hit = valid && tag match.
- Read hit: cpu_dout = addressed word in that cycle; stall = 0. Latency is exactly 1 cycle.
- Write hit: at the next edge, bytes of the word with cpu_we[i] = 1 are replaced by cpu_din byte i; dirty is set. stall = 0.
- Miss:
  - stall = 1 combinationally in the lookup cycle.
  - If the victim is valid and dirty, go to WB; otherwise go to REFILL.
- FSM states: IDLE, WB, REFILL, RESPOND.
- WB:
  - Issues 4 write requests, words 0..3, at victim address {victim tag, index, word, 2'b00}.
  - A beat advances only on mem_req_valid && mem_req_ready.
  - mem_req_addr/rw/wdata are held stable while not accepted.
  - After the 4th accept: dirty = 0, go to REFILL.
- REFILL:
  - Issues 4 read requests for words 0..3 of the new line (issue counter).
  - Independently counts 4 mem_resp_valid beats (receive counter) and writes beat k to word k.
  - Responses may arrive in the same cycle as later requests are accepted.
  - After the 4th response: tag written, valid = 1, dirty = 0, go to RESPOND.
- RESPOND:
  - One cycle. Reads the requested word to cpu_dout, or performs the write merge and sets dirty.
  - stall = 0 in this cycle; next state IDLE, and the next request is captured at this edge.
- mem_resp_valid outside REFILL, or beyond 4 beats, is ignored.
- mem_req_valid is never dropped before acceptance.
- Reset asserted mid-operation: immediate return to reset values. Lines partly refilled remain invalid.
- Counters are 2-bit and wrap; the 4th beat is detected on counter == 3 with the event present.
- Requests with no re/we produce no stall and no state change.

Test Plan:
- Reset release, then read 0x100 → stall = 1 from lookup cycle; read requests at 0x100, 0x104, 0x108, 0x10C; responses 0x11, 0x22, 0x33, 0x44 → in RESPOND cpu_dout = 0x11, stall = 0.
- Following read 0x108 → hit; cpu_dout = 0x33 one cycle later; stall = 0; no mem_req_valid.
- Write 0x104, cpu_we = 4'b0011, cpu_din = 0x0000BEEF → no stall. Then read 0x104 → cpu_dout = 0x0000BEEF merged as 0x0000BEEF | (0x22 upper bytes) = 0x0000BEEF (upper bytes of 0x00000022 are 0).
- Read 0x500 (same index, new tag, dirty victim) → 4 writes to 0x100..0x10C with data 0x11, 0x0000BEEF, 0x33, 0x44; then 4 reads at 0x500..0x50C; cpu_dout = first response.
- Hold mem_req_ready = 0 for 5 cycles during REFILL → mem_req_valid = 1 with constant addr/rw throughout; stall = 1; issue counter does not advance.
- Assert reset after 2 refill responses → stall = 0, mem_req_valid = 0 asynchronously. After release, read 0x100 misses again with a full 4-beat refill.
